// File: rtl/ddr_ctrl_pkg.sv
// Shared DDR controller definitions: command codes and the request
// arbiter's state encoding.
package ddr_ctrl_pkg;

   localparam logic [3:0] CMD_RD    = 4'd1;
   localparam logic [3:0] CMD_WR    = 4'd2;
   localparam logic [3:0] CMD_RD_AP = 4'd3;
   localparam logic [3:0] CMD_WR_AP = 4'd4;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_ISSUE     = 2'd1;
   localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;

   function automatic logic [3:0] cmd_code(input logic is_rd, input logic ap);
      if (ap)
         return is_rd ? CMD_RD_AP : CMD_WR_AP;
      return is_rd ? CMD_RD : CMD_WR;
   endfunction

endpackage

// File: rtl/ddr_rr_pick.sv
// 2-way round-robin port selector (0 = write, 1 = read) with an
// urgent-write override and a lock that pins a port during retries.
module ddr_rr_pick (
   input  logic wr_req,
   input  logic rd_req,
   input  logic urgent,
   input  logic ptr,
   input  logic lock,
   input  logic lock_port,
   output logic valid,
   output logic pick
);

   always_comb begin
      valid = 1'b0;
      pick  = 1'b0;
      if (lock) begin
         valid = 1'b1;
         pick  = lock_port;
      end else if (urgent && wr_req) begin
         valid = 1'b1;
         pick  = 1'b0;
      end else if (wr_req && rd_req) begin
         valid = 1'b1;
         pick  = ptr;
      end else if (wr_req || rd_req) begin
         valid = 1'b1;
         pick  = rd_req;
      end
   end

endmodule

// File: rtl/ddr_req_arbiter.sv
// Serialises camera-write and HDR-read burst requests into one-cycle DDR
// command strobes, tracks them through ctrl_busy and retries lost strobes.
module ddr_req_arbiter
   import ddr_ctrl_pkg::*;
#(
   parameter int ADDR_W    = 23,
   parameter bit AUTO_PRE  = 1'b1,
   parameter int ACK_WIN   = 2,
   parameter int MAX_RETRY = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_done,
   input  logic              ctrl_busy,
   output logic [3:0]        ctrl_cmd,
   output logic              ctrl_cmd_valid,
   output logic [ADDR_W-1:0] ctrl_addr,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_urgent,
   output logic              wr_grant,
   output logic              wr_done,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_grant,
   output logic              rd_done,
   output logic              err
);

   localparam int WIN_W = $clog2(ACK_WIN + 1);
   localparam int RTY_W = $clog2(MAX_RETRY + 1);

   logic [1:0]       state;
   logic [WIN_W-1:0] win_cnt;
   logic [RTY_W-1:0] rty_cnt;
   logic             rr_ptr;
   logic             locked;
   logic             port;
   logic             pick_valid;
   logic             pick;
   logic             win_end;

   ddr_rr_pick u_pick (
      .wr_req    (wr_req),
      .rd_req    (rd_req),
      .urgent    (wr_urgent),
      .ptr       (rr_ptr),
      .lock      (locked),
      .lock_port (port),
      .valid     (pick_valid),
      .pick      (pick)
   );

   assign win_end = (win_cnt == WIN_W'(ACK_WIN - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         win_cnt        <= '0;
         rty_cnt        <= '0;
         rr_ptr         <= 1'b0;
         locked         <= 1'b0;
         port           <= 1'b0;
         ctrl_cmd       <= '0;
         ctrl_cmd_valid <= 1'b0;
         ctrl_addr      <= '0;
         wr_grant       <= 1'b0;
         wr_done        <= 1'b0;
         rd_grant       <= 1'b0;
         rd_done        <= 1'b0;
         err            <= 1'b0;
      end else begin
         ctrl_cmd_valid <= 1'b0;
         wr_grant       <= 1'b0;
         wr_done        <= 1'b0;
         rd_grant       <= 1'b0;
         rd_done        <= 1'b0;
         case (state)
            ST_IDLE: begin
               // busy here is a refresh window (or a command left over from reset)
               if (init_done && !ctrl_busy && pick_valid) begin
                  port      <= pick;
                  ctrl_cmd  <= cmd_code(pick, AUTO_PRE);
                  ctrl_addr <= pick ? rd_addr : wr_addr;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               ctrl_cmd_valid <= 1'b1;
               win_cnt        <= '0;
               state          <= ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (ctrl_busy) begin
                  wr_grant <= ~port;
                  rd_grant <= port;
                  rr_ptr   <= ~port;
                  rty_cnt  <= '0;
                  state    <= ST_WAIT_DONE;
               end else if (win_end) begin
                  // strobe lost: re-issue the same port without re-arbitrating
                  locked <= 1'b1;
                  if (rty_cnt != RTY_W'(MAX_RETRY))
                     rty_cnt <= rty_cnt + RTY_W'(1);
                  if (rty_cnt >= RTY_W'(MAX_RETRY - 1))
                     err <= 1'b1;
                  state <= ST_IDLE;
               end else begin
                  win_cnt <= win_cnt + WIN_W'(1);
               end
            end
            ST_WAIT_DONE: begin
               if (!ctrl_busy) begin
                  wr_done <= ~port;
                  rd_done <= port;
                  locked  <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Testbench for ddr_req_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_ddr_req_arbiter;

   localparam int ADDR_W    = 23;
   localparam bit AUTO_PRE  = 1'b1;
   localparam int ACK_WIN   = 2;
   localparam int MAX_RETRY = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              init_done = 1'b0;
   logic              ctrl_busy = 1'b0;
   logic [3:0]        ctrl_cmd;
   logic              ctrl_cmd_valid;
   logic [ADDR_W-1:0] ctrl_addr;
   logic              wr_req = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic              wr_urgent = 1'b0;
   logic              wr_grant;
   logic              wr_done;
   logic              rd_req = 1'b0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic              rd_grant;
   logic              rd_done;
   logic              err;

   ddr_req_arbiter #(
      .ADDR_W    (ADDR_W),
      .AUTO_PRE  (AUTO_PRE),
      .ACK_WIN   (ACK_WIN),
      .MAX_RETRY (MAX_RETRY)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .init_done      (init_done),
      .ctrl_busy      (ctrl_busy),
      .ctrl_cmd       (ctrl_cmd),
      .ctrl_cmd_valid (ctrl_cmd_valid),
      .ctrl_addr      (ctrl_addr),
      .wr_req         (wr_req),
      .wr_addr        (wr_addr),
      .wr_urgent      (wr_urgent),
      .wr_grant       (wr_grant),
      .wr_done        (wr_done),
      .rd_req         (rd_req),
      .rd_addr        (rd_addr),
      .rd_grant       (rd_grant),
      .rd_done        (rd_done),
      .err            (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   bit                m_active, m_acked, m_lock, m_port, m_prefer_rd, m_err;
   int                m_t, m_retries;
   logic [3:0]        m_cmd = '0;
   logic [ADDR_W-1:0] m_addr = '0;
   bit                m_strobe, m_wg, m_rg, m_wd, m_rd;

   always @(posedge clk) begin
      m_strobe = 0; m_wg = 0; m_rg = 0; m_wd = 0; m_rd = 0;
      if (rst) begin
         m_active = 0; m_acked = 0; m_lock = 0; m_port = 0;
         m_prefer_rd = 0; m_err = 0; m_t = 0; m_retries = 0;
         m_cmd = '0; m_addr = '0;
      end else if (!m_active) begin
         if (init_done && !ctrl_busy && (m_lock || wr_req || rd_req)) begin
            if (!m_lock) begin
               if (wr_urgent && wr_req) m_port = 0;
               else if (wr_req && rd_req) m_port = m_prefer_rd;
               else m_port = rd_req;
            end
            m_active = 1; m_acked = 0; m_t = 0;
            if (m_port) m_cmd = AUTO_PRE ? 4'd3 : 4'd1;
            else        m_cmd = AUTO_PRE ? 4'd4 : 4'd2;
            m_addr = m_port ? rd_addr : wr_addr;
         end
      end else if (!m_acked) begin
         m_t++;
         if (m_t == 1) m_strobe = 1;
         else if (ctrl_busy) begin
            if (m_port) m_rg = 1; else m_wg = 1;
            m_acked = 1; m_prefer_rd = !m_port; m_retries = 0;
         end else if (m_t == ACK_WIN + 1) begin
            if (m_retries < MAX_RETRY) m_retries++;
            if (m_retries >= MAX_RETRY) m_err = 1;
            m_lock = 1; m_active = 0;
         end
      end else if (!ctrl_busy) begin
         if (m_port) m_rd = 1; else m_wd = 1;
         m_active = 0; m_lock = 0;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("cmd", ctrl_cmd, m_cmd);
         check("addr", ctrl_addr, m_addr);
         check("strobe", ctrl_cmd_valid, m_strobe);
         check("wr_grant", wr_grant, m_wg);
         check("rd_grant", rd_grant, m_rg);
         check("wr_done", wr_done, m_wd);
         check("rd_done", rd_done, m_rd);
         check("err", err, m_err);
      end
   end

   // ---------------- controller / client driver ----------------
   int cyc = 0;
   int hold_cnt = 0, refr_cnt = 0, drop_cnt = 0, hold_len = 12;
   bit never_ack = 0, hold_reqs = 0, rnd = 0;
   int wg_cnt = 0, rg_cnt = 0, wd_cnt = 0, rd_cnt = 0;
   logic [3:0]        log_cmd[$];
   logic [ADDR_W-1:0] log_addr[$];
   int                log_t[$];

   task automatic step();
      @(negedge clk);
      cyc++;
      if (ctrl_cmd_valid) begin
         log_cmd.push_back(ctrl_cmd);
         log_addr.push_back(ctrl_addr);
         log_t.push_back(cyc);
         if (drop_cnt > 0) drop_cnt--;
         else if (rnd) begin
            if ($urandom_range(0, 99) >= 15) hold_cnt = $urandom_range(1, 8);
         end else if (!never_ack) hold_cnt = hold_len;
      end
      if (wr_grant) wg_cnt++;
      if (rd_grant) rg_cnt++;
      if (wr_done) wd_cnt++;
      if (rd_done) rd_cnt++;
      if (rnd && hold_cnt == 0 && refr_cnt == 0 && $urandom_range(0, 99) < 3)
         refr_cnt = $urandom_range(1, 9);
      ctrl_busy = (hold_cnt > 0) || (refr_cnt > 0);
      if (hold_cnt > 0) hold_cnt--;
      if (refr_cnt > 0) refr_cnt--;
      if (!hold_reqs) begin
         if (wr_done) wr_req = 0;
         if (rd_done) rd_req = 0;
      end
      if (rnd) begin
         init_done = ($urandom_range(0, 19) != 0);
         wr_urgent = ($urandom_range(0, 4) == 0);
         if (!wr_req && !wr_done && $urandom_range(0, 99) < 30) begin
            wr_req = 1; wr_addr = ADDR_W'($urandom);
         end
         if (!rd_req && !rd_done && $urandom_range(0, 99) < 30) begin
            rd_req = 1; rd_addr = ADDR_W'($urandom);
         end
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_cmd"}, ctrl_cmd, 0);
      check({tag, "_valid"}, ctrl_cmd_valid, 0);
      check({tag, "_addr"}, ctrl_addr, 0);
      check({tag, "_grants"}, {wr_grant, rd_grant}, 0);
      check({tag, "_dones"}, {wr_done, rd_done}, 0);
      check({tag, "_err"}, err, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1; wr_req = 0; rd_req = 0; wr_urgent = 0; ctrl_busy = 0;
      hold_cnt = 0; refr_cnt = 0; drop_cnt = 0; hold_len = 12;
      never_ack = 0; hold_reqs = 0; rnd = 0; init_done = 1;
      #1;
      check_outputs_zero("reset");
      step();
      step();
      #2 rst = 0;
      log_cmd.delete(); log_addr.delete(); log_t.delete();
      wg_cnt = 0; rg_cnt = 0; wd_cnt = 0; rd_cnt = 0;
   endtask

   initial begin
      int n;
      int c0;

      // single write with auto-precharge
      do_reset();
      wr_addr = ADDR_W'(24'h1234);
      wr_req = 1;
      n = 0;
      while (wd_cnt < 1 && n < 100) begin step(); n++; end
      check("t1_wait", n < 100, 1);
      step(); step();
      check("t1_nstrobes", log_cmd.size(), 1);
      if (log_cmd.size() > 0) begin
         check("t1_cmd", log_cmd[0], 4);
         check("t1_addr", log_addr[0], 32'h1234);
      end
      check("t1_wgrants", wg_cnt, 1);
      check("t1_wdones", wd_cnt, 1);
      check("t1_rgrants", rg_cnt, 0);

      // both ports held together: W,R,W,R
      do_reset();
      hold_len = 3; hold_reqs = 1;
      wr_addr = ADDR_W'(24'h100); rd_addr = ADDR_W'(24'h200);
      wr_req = 1; rd_req = 1;
      n = 0;
      while (log_cmd.size() < 4 && n < 200) begin step(); n++; end
      check("t2_wait", n < 200, 1);
      hold_reqs = 0;
      repeat (60) step();
      if (log_cmd.size() >= 4) begin
         check("t2_ord0", log_cmd[0], 4);
         check("t2_ord1", log_cmd[1], 3);
         check("t2_ord2", log_cmd[2], 4);
         check("t2_ord3", log_cmd[3], 3);
         for (int i = 1; i < 4; i++)
            check("t2_spacing", (log_t[i] - log_t[i-1]) >= 4, 1);
      end

      // urgent write overtakes a pending read the pointer would favour
      do_reset();
      hold_len = 3;
      wr_addr = ADDR_W'(24'h0A0); wr_req = 1;
      n = 0;
      while (wd_cnt < 1 && n < 100) begin step(); n++; end
      refr_cnt = 6;
      step();
      rd_addr = ADDR_W'(24'h0B0); rd_req = 1;
      step(); step();
      wr_addr = ADDR_W'(24'h0C0); wr_req = 1; wr_urgent = 1;
      n = 0;
      while (rd_cnt < 1 && n < 150) begin step(); n++; end
      check("t3_wait", n < 150, 1);
      wr_urgent = 0;
      check("t3_nstrobes", log_cmd.size(), 3);
      if (log_cmd.size() >= 3) begin
         check("t3_second_cmd", log_cmd[1], 4);
         check("t3_second_addr", log_addr[1], 32'h0C0);
         check("t3_third_cmd", log_cmd[2], 3);
         check("t3_third_addr", log_addr[2], 32'h0B0);
      end

      // two strobes swallowed, third accepted
      do_reset();
      hold_len = 4; drop_cnt = 2;
      rd_addr = ADDR_W'(24'h2ABCD); rd_req = 1;
      n = 0;
      while (rd_cnt < 1 && n < 150) begin step(); n++; end
      check("t4_wait", n < 150, 1);
      check("t4_nstrobes", log_cmd.size(), 3);
      for (int i = 0; i < log_cmd.size(); i++) begin
         check("t4_addr", log_addr[i], 32'h2ABCD);
         check("t4_cmd", log_cmd[i], 3);
      end
      check("t4_rgrants", rg_cnt, 1);
      check("t4_err", err, 0);

      // controller never acks: err after third failed window, strobes go on
      do_reset();
      never_ack = 1;
      wr_addr = ADDR_W'(24'h777); wr_req = 1;
      n = 0;
      while (!err && n < 100) begin step(); n++; end
      check("t5_err_set", err, 1);
      check("t5_strobes_at_err", log_cmd.size(), 3);
      repeat (20) step();
      check("t5_strobes_continue", log_cmd.size() >= 7, 1);
      check("t5_err_sticky", err, 1);

      // refresh blocks issue; reset during WAIT_DONE
      do_reset();
      refr_cnt = 9;
      step();
      c0 = cyc;
      wr_addr = ADDR_W'(24'h3C3C); wr_req = 1;
      hold_len = 30;
      n = 0;
      while (log_cmd.size() < 1 && n < 60) begin step(); n++; end
      check("t6_wait_strobe", n < 60, 1);
      if (log_t.size() > 0)
         check("t6_strobe_cycle", log_t[0], c0 + 11);
      n = 0;
      while (wg_cnt < 1 && n < 40) begin step(); n++; end
      check("t6_wait_grant", n < 40, 1);
      step(); step();
      #2 rst = 1;
      #1 check_outputs_zero("midrst");
      hold_len = 4;
      step();
      #2 rst = 0;
      n = 0;
      while (wd_cnt < 1 && n < 120) begin step(); n++; end
      check("t6_wait_done", n < 120, 1);
      check("t6_wdones", wd_cnt, 1);

      // randomized traffic, checked cycle by cycle against the model
      do_reset();
      rnd = 1;
      repeat (2000) step();
      rnd = 0;
      init_done = 1;
      repeat (80) step();
      check("rand_activity", (wd_cnt + rd_cnt) > 50, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
